// File: rtl/branch_pkg.sv
// Shared definitions for the branch requester.
// Holds the opcode and state enums, the decoded instruction view and the
// jump-distance table that maps a 4-bit index to a PC jump amount.
package branch_pkg;

  localparam int LUT_DEPTH_DEF = 16;
  localparam int AMT_W_DEF     = 8;
  localparam int INSTR_W       = 9;

  typedef enum logic [3:0] {
    OP_BN  = 4'hC,
    OP_BNZ = 4'hD,
    OP_BZ  = 4'hE,
    OP_JMP = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  // Field view of the 9-bit instruction word: [8:5] op, [4] dir, [3:0] idx.
  typedef struct packed {
    logic [3:0] op;
    logic       dir;
    logic [3:0] idx;
  } instr_t;

  // Jump distances; entry 0 is a legal zero-length taken branch.
  localparam logic [AMT_W_DEF-1:0] JUMP_LUT [LUT_DEPTH_DEF] = '{
    8'd0,  8'd2,  8'd5,  8'd8,  8'd12, 8'd16, 8'd20,  8'd24,
    8'd32, 8'd40, 8'd48, 8'd64, 8'd80, 8'd96, 8'd112, 8'd127
  };

  function automatic logic is_branch(input logic [3:0] op);
    return (op == OP_JMP) || (op == OP_BZ) || (op == OP_BNZ) || (op == OP_BN);
  endfunction

endpackage

// File: rtl/jump_lut.sv
// Combinational jump-distance lookup.
// Ports: idx - table index; amt - jump distance for that index.
module jump_lut
  import branch_pkg::*;
#(
  parameter int LUT_DEPTH = LUT_DEPTH_DEF,
  parameter int AMT_W     = AMT_W_DEF,
  localparam int IDX_W    = $clog2(LUT_DEPTH)
) (
  input  logic [IDX_W-1:0] idx,
  output logic [AMT_W-1:0] amt
);

  always_comb amt = AMT_W'(JUMP_LUT[idx]);

endmodule

// File: rtl/branch_ctrl.sv
// Branch requester for the program counter's branch interface.
// Latches fetched instructions into an IR, keeps ALU zero/neg flags, decodes
// branch opcodes and drives BranchEnable/BranchTaken/JumpDirection/JumpAmount
// combinationally so the PC samples them at the next edge. A taken branch
// squashes the following IR word (one flush bubble).
// Ports:
//   CLK, init_n (sync active-low reset), halt (freeze until reset)
//   instr_valid/instr  - fetched word
//   flag_we/zero_in/neg_in - ALU flag update (also bypassed into the condition)
//   BranchEnable, BranchTaken, JumpDirection, JumpAmount - PC branch interface
//   flush - current IR word is a bubble; ir_valid - IR holds a live word
// Optional: define BRANCH_STATS_EN to add saturating taken_cnt/nottaken_cnt.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int LUT_DEPTH = LUT_DEPTH_DEF,
  parameter int AMT_W     = AMT_W_DEF
) (
  input  logic               CLK,
  input  logic               init_n,
  input  logic               halt,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  input  logic               flag_we,
  input  logic               zero_in,
  input  logic               neg_in,
  output logic               BranchEnable,
  output logic               BranchTaken,
  output logic               JumpDirection,
  output logic [AMT_W-1:0]   JumpAmount,
  output logic               flush,
  output logic               ir_valid
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]        taken_cnt,
  output logic [15:0]        nottaken_cnt
`endif
);

  localparam int IDX_W = $clog2(LUT_DEPTH);

  state_e           state, state_nxt;
  instr_t           ir;
  logic             ir_vld;
  logic             zero_q, neg_q;
  logic             zero_eff, neg_eff, cond;
  logic [AMT_W-1:0] lut_amt;

  // IR and flags; all of it freezes in HALT
  always_ff @(posedge CLK) begin
    if (!init_n) begin
      ir     <= '0;
      ir_vld <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (state != ST_HALT) begin
      if (instr_valid) ir <= instr_t'(instr);
      ir_vld <= instr_valid;
      if (flag_we) begin
        zero_q <= zero_in;
        neg_q  <= neg_in;
      end
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!init_n) state <= ST_RUN;
    else         state <= state_nxt;
  end

  // Next state; halt overrides everything and only reset leaves HALT
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RUN:   if (BranchTaken) state_nxt = ST_FLUSH;
      ST_FLUSH: state_nxt = ST_RUN;
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_RUN;
    endcase
    if (halt) state_nxt = ST_HALT;
  end

  jump_lut #(.LUT_DEPTH(LUT_DEPTH), .AMT_W(AMT_W)) u_lut (
    .idx (ir.idx[IDX_W-1:0]),
    .amt (lut_amt)
  );

  // A flag write in the same cycle as the branch wins over the stored flags
  always_comb begin
    zero_eff = flag_we ? zero_in : zero_q;
    neg_eff  = flag_we ? neg_in  : neg_q;
    unique case (ir.op)
      OP_JMP:  cond = 1'b1;
      OP_BZ:   cond = zero_eff;
      OP_BNZ:  cond = ~zero_eff;
      OP_BN:   cond = neg_eff;
      default: cond = 1'b0;
    endcase
  end

  // Outputs
  always_comb begin
    BranchEnable  = 1'b0;
    BranchTaken   = 1'b0;
    JumpDirection = 1'b0;
    JumpAmount    = '0;
    flush         = 1'b0;
    ir_valid      = 1'b0;
    if (state != ST_HALT) begin
      ir_valid     = ir_vld;
      flush        = (state == ST_FLUSH);
      BranchEnable = ir_vld & is_branch(ir.op) & (state == ST_RUN);
      if (BranchEnable) begin
        BranchTaken   = cond;
        JumpDirection = ir.dir;
        JumpAmount    = lut_amt;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge CLK) begin
    if (!init_n) begin
      taken_cnt    <= '0;
      nottaken_cnt <= '0;
    end else if (BranchEnable) begin
      if (BranchTaken) begin
        if (taken_cnt != 16'hFFFF) taken_cnt <= taken_cnt + 16'd1;
      end else begin
        if (nottaken_cnt != 16'hFFFF) nottaken_cnt <= nottaken_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;

  logic       CLK = 1'b0;
  logic       init_n, halt, instr_valid, flag_we, zero_in, neg_in;
  logic [8:0] instr;
  logic       BranchEnable, BranchTaken, JumpDirection, flush, ir_valid;
  logic [7:0] JumpAmount;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt, nottaken_cnt;
`endif

  branch_ctrl dut (
    .CLK(CLK), .init_n(init_n), .halt(halt), .instr_valid(instr_valid),
    .instr(instr), .flag_we(flag_we), .zero_in(zero_in), .neg_in(neg_in),
    .BranchEnable(BranchEnable), .BranchTaken(BranchTaken),
    .JumpDirection(JumpDirection), .JumpAmount(JumpAmount),
    .flush(flush), .ir_valid(ir_valid)
`ifdef BRANCH_STATS_EN
    , .taken_cnt(taken_cnt), .nottaken_cnt(nottaken_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model (0 RUN, 1 FLUSH, 2 HALT)
  logic [7:0]  m_lut [16];
  int          m_st;
  logic [8:0]  m_ir;
  logic        m_vld, m_z, m_n;
  logic [15:0] m_tc, m_nc;
  logic [12:0] sb [$];
  string       cur_tag;
  bit          checking = 0;

  function automatic logic [12:0] mdl_out();
    logic [3:0] op;
    logic zf, nf, cond, be;
    op = m_ir[8:5];
    zf = flag_we ? zero_in : m_z;
    nf = flag_we ? neg_in : m_n;
    case (op)
      4'hF:    cond = 1'b1;
      4'hE:    cond = zf;
      4'hD:    cond = !zf;
      4'hC:    cond = nf;
      default: cond = 1'b0;
    endcase
    if (m_st == 2) return 13'd0;
    be = m_vld && (m_st == 0) && (op >= 4'hC);
    return {m_vld, (m_st == 1), be, be && cond, be && m_ir[4], be ? m_lut[m_ir[3:0]] : 8'd0};
  endfunction

  function automatic logic [12:0] dut_out();
    return {ir_valid, flush, BranchEnable, BranchTaken, JumpDirection, JumpAmount};
  endfunction

  // Drive one cycle's inputs (called at negedge), push the expectation
  task automatic drive(input string tag, input logic rn, input logic iv, input logic [8:0] ins,
                       input logic fwe, input logic zi, input logic ni, input logic hl);
    init_n = rn; instr_valid = iv; instr = ins; flag_we = fwe;
    zero_in = zi; neg_in = ni; halt = hl;
    cur_tag = tag;
    sb.push_back(mdl_out());
    #1;
  endtask

  // Pop/compare, advance the model across the coming posedge, wait for next negedge
  task automatic fin();
    logic [12:0] e;
    e = sb.pop_front();
    if (checking) begin
      chk(cur_tag, 32'(dut_out()), 32'(e));
`ifdef BRANCH_STATS_EN
      chk({cur_tag, "_cnt"}, {taken_cnt, nottaken_cnt}, {m_tc, m_nc});
`endif
    end
    if (!init_n) begin
      m_st = 0; m_ir = '0; m_vld = 0; m_z = 0; m_n = 0; m_tc = 0; m_nc = 0;
    end else begin
      if (e[10]) begin
        if (e[9]) begin if (m_tc != 16'hFFFF) m_tc++; end
        else      begin if (m_nc != 16'hFFFF) m_nc++; end
      end
      if (m_st != 2) begin
        if (instr_valid) m_ir = instr;
        m_vld = instr_valid;
        if (flag_we) begin m_z = zero_in; m_n = neg_in; end
      end
      if (halt)                   m_st = 2;
      else if (m_st == 0 && e[9]) m_st = 1;
      else if (m_st == 1)         m_st = 0;
    end
    @(negedge CLK);
  endtask

  initial begin
    m_lut = '{8'd0, 8'd2, 8'd5, 8'd8, 8'd12, 8'd16, 8'd20, 8'd24,
              8'd32, 8'd40, 8'd48, 8'd64, 8'd80, 8'd96, 8'd112, 8'd127};
    m_st = 0; m_ir = '0; m_vld = 0; m_z = 0; m_n = 0; m_tc = 0; m_nc = 0;
    @(negedge CLK);

    // reset with a branch on the fetch bus
    drive("rst0", 0, 1, 9'h1E3, 0, 0, 0, 0); fin();
    checking = 1;
    drive("rst1", 0, 1, 9'h1E3, 0, 0, 0, 0);
    chk("rst_outs", 32'(dut_out()), 32'd0);
    fin();
    drive("rel", 1, 0, 9'h000, 0, 0, 0, 0);
    chk("rel_irv", 32'(ir_valid), 32'd0);
    fin();

    // JMP forward, then a branch word that must be squashed
    drive("jmp_ld", 1, 1, 9'h1F2, 0, 0, 0, 0); fin();
    drive("jmp", 1, 1, 9'h1C1, 0, 0, 0, 0);
    chk("jmp_fields", {BranchEnable, BranchTaken, JumpDirection, JumpAmount}, {3'b111, 8'd5});
    fin();
    drive("jmp_bub", 1, 1, 9'h045, 0, 0, 0, 0);
    chk("jmp_bub", {flush, BranchEnable}, 2'b10);
    fin();

    // non-branch, then BZ with same-cycle flag bypass
    drive("nonbr", 1, 1, 9'h1C1, 0, 0, 0, 0);
    chk("nonbr_be", 32'(BranchEnable), 32'd0);
    fin();
    drive("bz_byp", 1, 1, 9'h1C1, 1, 1, 0, 0);
    chk("bz_byp_bt", 32'(BranchTaken), 32'd1);
    fin();
    drive("bz_bub", 1, 0, 9'h000, 1, 0, 0, 0); fin();
    drive("bz_ld", 1, 1, 9'h1C1, 0, 0, 0, 0); fin();
    drive("bz_nt", 1, 1, 9'h045, 0, 0, 0, 0);
    chk("bz_nt", {BranchEnable, BranchTaken}, 2'b10);
    fin();
    drive("bz_noflush", 1, 0, 9'h000, 1, 0, 1, 0);
    chk("bz_noflush", 32'(flush), 32'd0);
    fin();

    // BN backward with neg=1, then BNZ with zero-length jump
    drive("bn_ld", 1, 1, 9'h181, 0, 0, 0, 0); fin();
    drive("bn", 1, 1, 9'h1A0, 0, 0, 0, 0);
    chk("bn_fields", {BranchTaken, JumpDirection, JumpAmount}, {2'b10, 8'd2});
    fin();
    drive("bn_bub", 1, 1, 9'h1A0, 0, 0, 0, 0); fin();
    drive("bnz0", 1, 1, 9'h045, 0, 0, 0, 0);
    chk("bnz0", {BranchTaken, JumpAmount}, {1'b1, 8'd0});
    fin();

    // halt during FLUSH, everything frozen until reset
    drive("halt_in", 1, 1, 9'h1F2, 0, 0, 0, 1); fin();
    for (int i = 0; i < 3; i++) begin
      drive("halted", 1, 1, 9'h1F2, 1, 1, 1, 0);
      chk("halt_outs", 32'(dut_out()), 32'd0);
      fin();
    end
    drive("halt_rst", 0, 0, 9'h000, 0, 0, 0, 0); fin();
    drive("post_rst", 1, 1, 9'h1F3, 0, 0, 0, 0);
    chk("post_rst_irv", 32'(ir_valid), 32'd0);
    fin();
    drive("run_again", 1, 1, 9'h045, 0, 0, 0, 0);
    chk("run_again_bt", {BranchTaken, JumpAmount}, {1'b1, 8'd8});
    fin();

    // 3 taken + 2 not-taken from a clean reset
    drive("st_rst", 0, 0, 9'h000, 0, 0, 0, 0); fin();
    drive("st0", 1, 1, 9'h1F2, 0, 0, 0, 0); fin();
    drive("st1", 1, 1, 9'h045, 0, 0, 0, 0); fin();
    drive("st2", 1, 1, 9'h1F2, 0, 0, 0, 0); fin();
    drive("st3", 1, 1, 9'h045, 0, 0, 0, 0); fin();
    drive("st4", 1, 1, 9'h1F2, 0, 0, 0, 0); fin();
    drive("st5", 1, 1, 9'h1C1, 0, 0, 0, 0); fin();
    drive("st6", 1, 1, 9'h1C1, 0, 0, 0, 0); fin();
    drive("st7", 1, 1, 9'h1C1, 0, 0, 0, 0); fin();
    drive("st8", 1, 1, 9'h045, 0, 0, 0, 0); fin();
    drive("st9", 1, 0, 9'h000, 0, 0, 0, 0);
`ifdef BRANCH_STATS_EN
    chk("stats", {taken_cnt, nottaken_cnt}, {16'd3, 16'd2});
`endif
    fin();

    // random traffic biased toward branch opcodes
    for (int i = 0; i < 400; i++) begin
      logic [8:0] w;
      w = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 1) == 1) w[8:7] = 2'b11;
      drive("rnd", ($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0), w,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 49) == 0));
      fin();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
